lab3_horner_mc: RTL and testbench

Parametrised multicycle polynomial evaluator, the successor to the lab2 single-function multicycle unit. It computes y = sum(coef[k]*x^k) by Horner's rule, using one shared multiply-add per cycle. The start/rdy handshake matches the lab2_mc style. It adds generic width and degree, runtime coefficients, a busy output and overflow detection, and it sits beside the lab2 units under the same lab bench.

---
 rtl/lab3_pkg.sv | 17 +
 rtl/lab3_mac.sv | 41 ++++
 rtl/lab3_horner_mc.sv | 153 +++++++++++++++
 tb/tb_lab3_horner_mc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// rtl/lab3_pkg.sv - shared types and helpers for the lab3 Horner evaluator
// Purpose: FSM state enum and the coefficient-slice helper used by the
//          lab3 polynomial units.
// Ports:   none (package).
package lab3_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // LSB position of coefficient k inside the packed coefficient bus.
    function automatic int coef_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/lab3_mac.sv
// rtl/lab3_mac.sv - combinational signed multiply-add with overflow detect
// Purpose: sum = acc*x + c, evaluated exactly at OUTW+WIDTH+1 bits and
//          wrapped to OUTW bits; o_ovf flags a result outside signed OUTW.
// Ports:   i_acc  [OUTW]  signed accumulator
//          i_x    [WIDTH] signed multiplier
//          i_c    [WIDTH] signed addend
//          o_sum  [OUTW]  wrapped signed result
//          o_ovf          exact result did not fit in OUTW bits
module lab3_mac #(
    parameter int WIDTH = 8,
    parameter int OUTW  = 16
) (
    input  logic signed [OUTW-1:0]  i_acc,
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_c,
    output logic signed [OUTW-1:0]  o_sum,
    output logic                    o_ovf
);

    localparam int FW = OUTW + WIDTH + 1;

    logic signed [FW-1:0]  w_acc_ext;
    logic signed [FW-1:0]  w_x_ext;
    logic signed [FW-1:0]  w_c_ext;
    logic signed [FW-1:0]  w_full;
    logic        [WIDTH+1:0] w_top;

    // Operands are extended to the full width so the product and sum are
    // exact; the truncated FW-bit product equals the true one.
    assign w_acc_ext = {{(WIDTH + 1){i_acc[OUTW-1]}}, i_acc};
    assign w_x_ext   = {{(OUTW + 1){i_x[WIDTH-1]}}, i_x};
    assign w_c_ext   = {{(OUTW + 1){i_c[WIDTH-1]}}, i_c};
    assign w_full    = w_acc_ext * w_x_ext + w_c_ext;

    // Result fits in OUTW bits only if the bits above the OUTW sign bit are
    // all copies of it.
    assign w_top = w_full[FW-1:OUTW-1];
    assign o_sum = w_full[OUTW-1:0];
    assign o_ovf = ~((&w_top) | ~(|w_top));

endmodule

// File: rtl/lab3_horner_mc.sv
// rtl/lab3_horner_mc.sv - multicycle polynomial evaluator using Horner's rule
// Purpose: y = sum(coef[k]*x^k), one shared multiply-add per cycle, with a
//          start/rdy handshake, busy indication and sticky overflow flag.
// Ports:   clk    rising-edge clock
//          rst    asynchronous active-low reset
//          start  request, sampled only in IDLE
//          x      [WIDTH] signed operand, latched on accepted start
//          coef   [(DEG+1)*WIDTH] coef[k] at bits k*WIDTH +: WIDTH
//          y      [OUTW] signed result, held until next completion
//          rdy    one-cycle pulse when y is updated
//          busy   high while calculating
//          ovf    overflow flag of last result, held with y
module lab3_horner_mc
    import lab3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEG   = 3,
    parameter int OUTW  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [WIDTH-1:0]      x,
    input  logic [(DEG+1)*WIDTH-1:0]     coef,
    output logic signed [OUTW-1:0]       y,
    output logic                         rdy,
    output logic                         busy,
    output logic                         ovf
);

    localparam int CNTW  = (DEG < 1) ? 1 : $clog2(DEG + 1);
    localparam bit MULTI = (DEG >= 1);

    state_t                      r_state;
    state_t                      w_next_state;
    logic signed [WIDTH-1:0]     r_x;
    logic [(DEG+1)*WIDTH-1:0]    r_coef;
    logic signed [OUTW-1:0]      r_acc;
    logic [CNTW-1:0]             r_cnt;
    logic                        r_ovf_int;
    logic signed [OUTW-1:0]      r_y;
    logic                        r_rdy;
    logic                        r_ovf;

    logic                        w_accept;
    logic                        w_busy;
    logic                        w_last;
    logic signed [WIDTH-1:0]     w_ctop;
    logic signed [WIDTH-1:0]     w_c;
    logic signed [OUTW-1:0]      w_sum;
    logic                        w_step_ovf;

    // Highest coefficient comes straight from the input bus: it seeds the
    // accumulator in the same edge that latches the operands.
    assign w_ctop = coef[coef_lsb(DEG, WIDTH) +: WIDTH];

    always_comb begin
        w_c = '0;
        for (int k = 0; k <= DEG; k++) begin
            if (r_cnt == CNTW'(k)) begin
                w_c = r_coef[coef_lsb(k, WIDTH) +: WIDTH];
            end
        end
    end

    lab3_mac #(
        .WIDTH (WIDTH),
        .OUTW  (OUTW)
    ) u_mac (
        .i_acc (r_acc),
        .i_x   (r_x),
        .i_c   (w_c),
        .o_sum (w_sum),
        .o_ovf (w_step_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    // Degree 0 needs no steps and completes from IDLE.
                    if (MULTI) begin
                        w_next_state = CALC;
                    end
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_last       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x       <= '0;
            r_coef    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_y       <= '0;
            r_rdy     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_accept) begin
                r_x       <= x;
                r_coef    <= coef;
                r_acc     <= OUTW'(w_ctop);
                r_cnt     <= CNTW'(DEG - 1);
                r_ovf_int <= 1'b0;
                if (!MULTI) begin
                    r_y   <= OUTW'(w_ctop);
                    r_ovf <= 1'b0;
                    r_rdy <= 1'b1;
                end
            end
            if (w_busy) begin
                r_acc     <= w_sum;
                r_ovf_int <= r_ovf_int | w_step_ovf;
                r_cnt     <= r_cnt - CNTW'(1);
                if (w_last) begin
                    r_y   <= w_sum;
                    r_ovf <= r_ovf_int | w_step_ovf;
                    r_rdy <= 1'b1;
                end
            end
        end
    end

    assign y    = r_y;
    assign rdy  = r_rdy;
    assign busy = w_busy;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_lab3_horner_mc.sv
// tb/tb_lab3_horner_mc.sv - self-checking bench for lab3_horner_mc
module tb_lab3_horner_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default instance: WIDTH=8, DEG=3, OUTW=16
    logic               start;
    logic signed [7:0]  x;
    logic [31:0]        coef;
    logic signed [15:0] y;
    logic               rdy, busy, ovf;

    // DEG=0 instance
    logic               start0;
    logic signed [7:0]  x0;
    logic [7:0]         coef0;
    logic signed [15:0] y0;
    logic               rdy0, busy0, ovf0;

    // WIDTH=16, OUTW=32, DEG=5 instance
    logic               start5;
    logic signed [15:0] x5;
    logic [95:0]        coef5;
    logic signed [31:0] y5;
    logic               rdy5, busy5, ovf5;

    lab3_horner_mc dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .coef(coef),
        .y(y), .rdy(rdy), .busy(busy), .ovf(ovf)
    );

    lab3_horner_mc #(.WIDTH(8), .DEG(0), .OUTW(16)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .x(x0), .coef(coef0),
        .y(y0), .rdy(rdy0), .busy(busy0), .ovf(ovf0)
    );

    lab3_horner_mc #(.WIDTH(16), .DEG(5), .OUTW(32)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .x(x5), .coef(coef5),
        .y(y5), .rdy(rdy5), .busy(busy5), .ovf(ovf5)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] C1234 = {8'd1, 8'd2, 8'd3, 8'd4};
    localparam logic [31:0] CONES = {8'd1, 8'd1, 8'd1, 8'd1};

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic signed [7:0] xv, input logic [31:0] cv, output int lat);
        x     = xv;
        coef  = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!rdy && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    function automatic void ref5(input logic signed [15:0] xv, input logic [95:0] cv,
                                 output longint yv, output longint ov);
        longint acc, full, lim_hi, lim_lo;
        logic signed [15:0] ck;
        lim_hi = 2147483647;
        lim_lo = -lim_hi - 1;
        ck  = cv[95:80];
        acc = longint'(ck);
        ov  = 0;
        for (int k = 4; k >= 0; k--) begin
            ck   = cv[k*16 +: 16];
            full = acc * longint'(xv) + longint'(ck);
            if (full > lim_hi || full < lim_lo) ov = 1;
            acc = longint'($signed(full[31:0]));
        end
        yv = acc;
    endfunction

    initial begin
        int lat, n_rdy, first_i, last_i, n_dbl, n_gap;
        logic prev_rdy;
        longint ey, eo;
        logic signed [15:0] cw;

        rst = 1'b0;
        start = 1'b0;  x = '0;  coef = '0;
        start0 = 1'b0; x0 = '0; coef0 = '0;
        start5 = 1'b0; x5 = '0; coef5 = '0;
        tick();
        tick();
        check("rst_y", y, 0);
        check("rst_rdy", rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_y0", y0, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 1: basic operation, busy and latency
        x = 8'sd2; coef = C1234; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy_e0", busy, 1);
        check("t1_rdy_e0", rdy, 0);
        tick();
        check("t1_busy_e1", busy, 1);
        tick();
        check("t1_busy_e2", busy, 1);
        check("t1_rdy_e2", rdy, 0);
        tick();
        check("t1_rdy_e3", rdy, 1);
        check("t1_busy_e3", busy, 0);
        check("t1_y", y, 26);
        check("t1_ovf", ovf, 0);
        tick();
        check("t1_rdy_e4", rdy, 0);
        check("t1_y_hold", y, 26);

        // 2: negative x
        run_op(-8'sd3, C1234, lat);
        check("t2_lat", lat, 3);
        check("t2_y", y, -14);
        check("t2_ovf", ovf, 0);

        // 3: overflow and per-operation clear
        run_op(8'sd127, CONES, lat);
        check("t3_y", y, -32512);
        check("t3_ovf", ovf, 1);
        tick();
        check("t3_ovf_hold", ovf, 1);
        check("t3_y_hold", y, -32512);
        run_op(8'sd1, CONES, lat);
        check("t3b_y", y, 4);
        check("t3b_ovf", ovf, 0);
        tick();

        // 4a: start held high -> one result every 4 cycles
        x = 8'sd2; coef = C1234; start = 1'b1;
        n_rdy = 0; first_i = -1; last_i = -1; n_dbl = 0; n_gap = 0; prev_rdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (rdy) begin
                if (prev_rdy) n_dbl++;
                if (first_i < 0) first_i = i;
                else if (i - last_i != 4) n_gap++;
                last_i = i;
                n_rdy++;
                if (y != 26) n_gap++;
            end
            prev_rdy = rdy;
        end
        start = 1'b0;
        check("t4_n_rdy", n_rdy, 4);
        check("t4_first_rdy", first_i, 3);
        check("t4_period", n_gap, 0);
        check("t4_single", n_dbl, 0);
        lat = 0;
        while (!rdy && lat < 20) begin tick(); lat++; end
        check("t4_drain_lat", lat, 3);
        tick();

        // 4b: start and x changes during CALC are ignored
        x = 8'sd2; coef = C1234; start = 1'b1;
        tick();
        x = 8'sd5;
        tick();
        tick();
        x = -8'sd7;
        tick();
        start = 1'b0;
        check("t4b_rdy", rdy, 1);
        check("t4b_y", y, 26);
        n_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rdy) n_rdy++;
        end
        check("t4b_no_extra", n_rdy, 0);
        check("t4b_busy", busy, 0);

        // 5: async reset mid-CALC
        run_op(8'sd127, CONES, lat);
        x = 8'sd2; coef = C1234; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("t5_y", y, 0);
        check("t5_rdy", rdy, 0);
        check("t5_busy", busy, 0);
        check("t5_ovf", ovf, 0);
        tick();
        #3;
        rst = 1'b1;
        n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rdy) n_rdy++;
        end
        check("t5_no_rdy", n_rdy, 0);
        run_op(-8'sd3, C1234, lat);
        check("t5_lat", lat, 3);
        check("t5_y_after", y, -14);

        // 6a: DEG=0
        coef0 = 8'hFB; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t6_d0_rdy", rdy0, 1);
        check("t6_d0_y", y0, -5);
        check("t6_d0_busy", busy0, 0);
        check("t6_d0_ovf", ovf0, 0);
        tick();
        check("t6_d0_rdy_low", rdy0, 0);
        check("t6_d0_y_hold", y0, -5);

        // 6b: WIDTH=16/OUTW=32/DEG=5 against a reference model
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 6; k++) begin
                if (i % 4 == 0) cw = 16'(int'($urandom_range(0, 15)) - 8);
                else            cw = 16'($urandom);
                coef5[k*16 +: 16] = cw;
            end
            if (i % 4 == 0) x5 = 16'(int'($urandom_range(0, 15)) - 8);
            else            x5 = 16'($urandom);
            ref5(x5, coef5, ey, eo);
            start5 = 1'b1;
            tick();
            start5 = 1'b0;
            lat = 0;
            while (!rdy5 && lat < 20) begin tick(); lat++; end
            check("t6_d5_lat", lat, 5);
            check("t6_d5_y", y5, ey);
            check("t6_d5_ovf", ovf5, eo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
